// File: rtl/b8_wb_pkg.sv
// Shared types for the write-back commit scheduler: pID type and the held request record.
package b8_wb_pkg;
    localparam int PID_W  = 2;
    localparam int DATA_W = 64;

    typedef logic [PID_W-1:0] pid_t;

    typedef struct packed {
        logic              we;
        logic [4:0]        rdAddr;
        logic [DATA_W-1:0] data;
        pid_t              pid;
    } wb_req_t;
endpackage

// File: rtl/wb_hold_slot.sv
// One-entry write-back holding register; flush beats load, load beats drain.
module wb_hold_slot
    import b8_wb_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    flush,
    input  logic    load,
    input  logic    drain,
    input  wb_req_t req_in,
    output logic    valid,
    output wb_req_t req
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            req   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            req   <= req_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_commit_scheduler.sv
// Commits WBU write-backs from two ways into a dual-port regfile in strict pID order.
// Optional same-cycle bypass of empty slots is enabled by defining WB_BYPASS_EN.
module wb_commit_scheduler #(
    parameter int DATA_W      = 64,
    parameter int PID_W       = 2,
    parameter int STALL_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_i,
    input  logic              way0_wbValid_i,
    input  logic              way0_rdWriteEnable_i,
    input  logic [4:0]        way0_rdAddr_i,
    input  logic [DATA_W-1:0] way0_rdData_i,
    input  logic [PID_W-1:0]  way0_WBU_pID_i,
    output logic              way0_ready_o,
    input  logic              way1_wbValid_i,
    input  logic              way1_rdWriteEnable_i,
    input  logic [4:0]        way1_rdAddr_i,
    input  logic [DATA_W-1:0] way1_rdData_i,
    input  logic [PID_W-1:0]  way1_WBU_pID_i,
    output logic              way1_ready_o,
    output logic              commit0_we_o,
    output logic [4:0]        commit0_rdAddr_o,
    output logic [DATA_W-1:0] commit0_rdData_o,
    output logic              commit1_we_o,
    output logic [4:0]        commit1_rdAddr_o,
    output logic [DATA_W-1:0] commit1_rdData_o,
    output logic [PID_W-1:0]  expectPID_o,
    output logic              deadlock_o
);
    import b8_wb_pkg::*;

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    wb_req_t          in_req   [2];
    wb_req_t          slot_req [2];
    wb_req_t          cand_req [2];
    wb_req_t          req0, req1;
    logic [1:0]       in_valid, slot_v, cand_v, cand_held;
    logic [1:0]       match0, match1, commit_way, drain, load, ready;
    logic             p0_v, p1_v, p0_way, we0, we1;
    logic [1:0]       n_commit;
    pid_t             expect_q, expect_p1, expect_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             deadlock_q;

    assign in_valid  = {way1_wbValid_i, way0_wbValid_i};
    assign in_req[0] = '{we: way0_rdWriteEnable_i, rdAddr: way0_rdAddr_i,
                         data: way0_rdData_i, pid: way0_WBU_pID_i};
    assign in_req[1] = '{we: way1_rdWriteEnable_i, rdAddr: way1_rdAddr_i,
                         data: way1_rdData_i, pid: way1_WBU_pID_i};

    for (genvar w = 0; w < 2; w++) begin : g_slot
        wb_hold_slot u_slot (
            .clk    (clk),
            .reset_n(reset_n),
            .flush  (flush_i),
            .load   (load[w]),
            .drain  (drain[w]),
            .req_in (in_req[w]),
            .valid  (slot_v[w]),
            .req    (slot_req[w])
        );
    end

    assign expect_p1 = expect_q + 1'b1;

    // Per-way candidate: the held slot, or (bypass only) the incoming request into an empty slot.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
`ifdef WB_BYPASS_EN
            cand_held[w] = slot_v[w];
            cand_v[w]    = slot_v[w] | (in_valid[w] & ~flush_i);
            cand_req[w]  = slot_v[w] ? slot_req[w] : in_req[w];
`else
            cand_held[w] = 1'b1;
            cand_v[w]    = slot_v[w];
            cand_req[w]  = slot_req[w];
`endif
            match0[w] = cand_v[w] && (cand_req[w].pid == expect_q);
            match1[w] = cand_v[w] && (cand_req[w].pid == expect_p1);
        end
        p0_v = ~flush_i & |match0;
        // Held entries first, way0 before way1 on a duplicate pID.
        if (match0[0] & cand_held[0])      p0_way = 1'b0;
        else if (match0[1] & cand_held[1]) p0_way = 1'b1;
        else if (match0[0])                p0_way = 1'b0;
        else                               p0_way = 1'b1;
        p1_v = p0_v & match1[~p0_way];
    end

    assign commit_way[0] = (p0_v & ~p0_way) | (p1_v &  p0_way);
    assign commit_way[1] = (p0_v &  p0_way) | (p1_v & ~p0_way);
    assign drain = commit_way & cand_held;
    assign ready = flush_i ? 2'b00 : (~slot_v | drain);
    // A bypassed request is consumed directly and must not also be captured.
    assign load  = in_valid & ready & ~(commit_way & ~cand_held);

    assign way0_ready_o = ready[0];
    assign way1_ready_o = ready[1];

    assign req0 = cand_req[p0_way];
    assign req1 = cand_req[~p0_way];
    assign we1  = p1_v & req1.we & (req1.rdAddr != 5'd0);
    assign we0  = p0_v & req0.we & (req0.rdAddr != 5'd0) & ~(we1 & (req0.rdAddr == req1.rdAddr));

    assign commit0_we_o     = we0;
    assign commit0_rdAddr_o = p0_v ? req0.rdAddr : 5'd0;
    assign commit0_rdData_o = p0_v ? req0.data : '0;
    assign commit1_we_o     = we1;
    assign commit1_rdAddr_o = p1_v ? req1.rdAddr : 5'd0;
    assign commit1_rdData_o = p1_v ? req1.data : '0;

    assign n_commit = {1'b0, p0_v} + {1'b0, p1_v};
    assign expect_d = expect_q + pid_t'(n_commit);

    always_comb begin
        stall_d = stall_q;
        if (n_commit != 2'd0 || slot_v == 2'b00)
            stall_d = '0;
        else if (stall_q != CNT_W'(STALL_LIMIT))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expect_q   <= '0;
            stall_q    <= '0;
            deadlock_q <= 1'b0;
        end else if (flush_i) begin
            expect_q   <= '0;
            stall_q    <= '0;
            deadlock_q <= 1'b0;
        end else begin
            expect_q <= expect_d;
            stall_q  <= stall_d;
            if (stall_d == CNT_W'(STALL_LIMIT))
                deadlock_q <= 1'b1;
        end
    end

    assign expectPID_o = expect_q;
    assign deadlock_o  = deadlock_q;

endmodule

// File: tb/tb_wb_commit_scheduler.sv
// Randomized and directed bench for wb_commit_scheduler against an in-bench behavioural model.
module tb_wb_commit_scheduler;
    localparam int DW = 64;
    localparam int PW = 2;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          vin  [2];
    logic          wein [2];
    logic [4:0]    ain  [2];
    logic [DW-1:0] din  [2];
    logic [PW-1:0] pin  [2];
    logic          r0, r1, cwe0, cwe1, dl;
    logic [4:0]    ca0, ca1;
    logic [DW-1:0] cd0, cd1;
    logic [PW-1:0] expo;

    wb_commit_scheduler #(.DATA_W(DW), .PID_W(PW), .STALL_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .way0_wbValid_i(vin[0]), .way0_rdWriteEnable_i(wein[0]), .way0_rdAddr_i(ain[0]),
        .way0_rdData_i(din[0]), .way0_WBU_pID_i(pin[0]), .way0_ready_o(r0),
        .way1_wbValid_i(vin[1]), .way1_rdWriteEnable_i(wein[1]), .way1_rdAddr_i(ain[1]),
        .way1_rdData_i(din[1]), .way1_WBU_pID_i(pin[1]), .way1_ready_o(r1),
        .commit0_we_o(cwe0), .commit0_rdAddr_o(ca0), .commit0_rdData_o(cd0),
        .commit1_we_o(cwe1), .commit1_rdAddr_o(ca1), .commit1_rdData_o(cd1),
        .expectPID_o(expo), .deadlock_o(dl)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: slot contents, expected pID, stall count, deadlock flag.
    bit            mv  [2];
    bit            mwe [2];
    logic [4:0]    ma  [2];
    logic [DW-1:0] md  [2];
    int            mpid[2];
    int            mexp, mstall;
    bit            mdl;
    // Model outputs for the current cycle.
    bit            ec0, ec1, ewe0, ewe1;
    int            ew0, ew1;
    bit            ecw [2];
    bit            erdy[2];
    logic [4:0]    ea0, ea1;
    logic [DW-1:0] ed0, ed1;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) mv[w] = 1'b0;
        mexp = 0; mstall = 0; mdl = 1'b0;
    endfunction

    function automatic void model_eval();
        ec0 = 1'b0; ec1 = 1'b0; ew0 = 0;
        for (int w = 0; w < 2; w++)
            if (!ec0 && mv[w] && mpid[w] == mexp) begin ec0 = 1'b1; ew0 = w; end
        ew1 = 1 - ew0;
        if (ec0 && mv[ew1] && mpid[ew1] == (mexp + 1) % 4) ec1 = 1'b1;
        if (flush_i) begin ec0 = 1'b0; ec1 = 1'b0; end
        for (int w = 0; w < 2; w++) begin
            ecw[w]  = (ec0 && ew0 == w) || (ec1 && ew1 == w);
            erdy[w] = !flush_i && (!mv[w] || ecw[w]);
        end
        ewe1 = ec1 && mwe[ew1] && ma[ew1] != 5'd0;
        ewe0 = ec0 && mwe[ew0] && ma[ew0] != 5'd0 && !(ewe1 && ma[ew0] == ma[ew1]);
        ea0 = ec0 ? ma[ew0] : 5'd0;  ed0 = ec0 ? md[ew0] : '0;
        ea1 = ec1 ? ma[ew1] : 5'd0;  ed1 = ec1 ? md[ew1] : '0;
    endfunction

    function automatic void model_update();
        int n;
        bit anyv;
        model_eval();
        if (flush_i) begin model_reset(); return; end
        anyv = mv[0] || mv[1];
        n = int'(ec0) + int'(ec1);
        mexp = (mexp + n) % 4;
        if (n > 0 || !anyv) mstall = 0;
        else if (mstall < SL) mstall++;
        if (mstall == SL) mdl = 1'b1;
        for (int w = 0; w < 2; w++) begin
            if (ecw[w]) mv[w] = 1'b0;
            if (vin[w] && erdy[w]) begin
                mv[w] = 1'b1; mwe[w] = wein[w]; ma[w] = ain[w]; md[w] = din[w]; mpid[w] = int'(pin[w]);
            end
        end
    endfunction

    task automatic compare();
        model_eval();
        check("way0_ready", r0, erdy[0]);
        check("way1_ready", r1, erdy[1]);
        check("commit0_we", cwe0, ewe0);
        check("commit0_addr", ca0, ea0);
        check("commit0_data", cd0, ed0);
        check("commit1_we", cwe1, ewe1);
        check("commit1_addr", ca1, ea1);
        check("commit1_data", cd1, ed1);
        check("expectPID", expo, mexp[PW-1:0]);
        check("deadlock", dl, mdl);
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are compared 3 units later.
    task automatic half();
        #3;
        compare();
    endtask

    task automatic fin();
        @(posedge clk);
        if (reset_n) model_update(); else model_reset();
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic drive(input int w, input bit we, input int a, input logic [DW-1:0] d, input int p);
        vin[w] = 1'b1; wein[w] = we; ain[w] = 5'(a); din[w] = d; pin[w] = PW'(p);
    endtask

    task automatic idle();
        for (int w = 0; w < 2; w++) vin[w] = 1'b0;
    endtask

    initial begin
        int nxt, first, acc[2];
        for (int w = 0; w < 2; w++) begin
            vin[w] = 1'b0; wein[w] = 1'b0; ain[w] = '0; din[w] = '0; pin[w] = '0;
        end
        model_reset();
        @(posedge clk); #1;

        // Reset state
        half();
        check("rst_expect", expo, 0);
        check("rst_deadlock", dl, 0);
        check("rst_we0", cwe0, 0);
        check("rst_ready0", r0, 1);
        reset_n = 1'b1;
        fin();

        // In-order pair
        drive(0, 1, 5, 'hAA, 0); drive(1, 1, 6, 'hBB, 1);
        step(); idle(); half();
        check("pair_we0", cwe0, 1);    check("pair_addr0", ca0, 5);  check("pair_data0", cd0, 'hAA);
        check("pair_we1", cwe1, 1);    check("pair_addr1", ca1, 6);  check("pair_data1", cd1, 'hBB);
        fin(); half(); check("pair_expect", expo, 2); fin();

        // Same destination, expect wraps 2 -> 0
        drive(0, 1, 7, 'h1, 2); drive(1, 1, 7, 'h2, 3);
        step(); idle(); half();
        check("same_we0", cwe0, 0); check("same_we1", cwe1, 1); check("same_data1", cd1, 'h2);
        fin(); half(); check("same_expect", expo, 0); fin();

        // Out of order: pID1 waits for pID0
        drive(1, 1, 9, 'h11, 1);
        step(); idle(); half();
        check("ooo_ready1_c1", r1, 0); check("ooo_we0_c1", cwe0, 0); check("ooo_we1_c1", cwe1, 0);
        fin(); drive(0, 1, 8, 'h22, 0); half();
        check("ooo_ready1_c2", r1, 0); check("ooo_we1_c2", cwe1, 0);
        fin(); idle(); half();
        check("ooo_we0_c3", cwe0, 1); check("ooo_addr0_c3", ca0, 8);
        check("ooo_we1_c3", cwe1, 1); check("ooo_addr1_c3", ca1, 9);
        fin();

        // Flush, then rd0 still consumes its pID
        flush_i = 1'b1; step(); flush_i = 1'b0;
        drive(0, 1, 0, 'h55, 0);
        step(); idle(); half();
        check("rd0_we0", cwe0, 0);
        fin(); half(); check("rd0_expect", expo, 1); fin();

        // Deadlock on a lone pID1 with expect=0
        flush_i = 1'b1; step(); flush_i = 1'b0;
        drive(1, 1, 3, 'h33, 1);
        step(); idle();
        repeat (3) step();
        half(); check("dl_before", dl, 0); fin();
        half(); check("dl_set", dl, 1); fin();
        flush_i = 1'b1; half(); check("flush_ready0", r0, 0); fin(); flush_i = 1'b0;
        half();
        check("flush_dl", dl, 0); check("flush_expect", expo, 0); check("flush_ready1", r1, 1);
        fin();

        // Async reset with both slots held
        drive(0, 1, 1, 'h1, 2); drive(1, 1, 2, 'h2, 3);
        step(); idle(); half();
        check("held_ready0", r0, 0);
        reset_n = 1'b0; #1;
        model_reset();
        check("arst_we0", cwe0, 0); check("arst_we1", cwe1, 0);
        check("arst_ready0", r0, 1); check("arst_ready1", r1, 1);
        compare();
        reset_n = 1'b1;
        @(posedge clk); model_update(); #1;

        // Randomized traffic
        nxt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush_i = ($urandom_range(0, 99) < 3);
            first = $urandom_range(0, 1);
            for (int k = 0; k < 2; k++) begin
                int w;
                w = (first + k) % 2;
                if (!vin[w] && $urandom_range(0, 99) < 60) begin
                    drive(w, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          {$urandom(), $urandom()},
                          ($urandom_range(0, 99) < 4) ? $urandom_range(0, 3) : nxt);
                    nxt = (nxt + 1) % 4;
                end
            end
            half();
            acc[0] = int'(vin[0] && r0);
            acc[1] = int'(vin[1] && r1);
            fin();
            if (flush_i) begin
                idle(); nxt = 0;
            end else begin
                for (int w = 0; w < 2; w++) if (acc[w] != 0) vin[w] = 1'b0;
            end
        end
        flush_i = 1'b0; idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
